// File: rtl/microforth_pkg.sv
// Shared constants and types for the microForth bring-up image:
// command/response bytes, parser states and heartbeat periods.
package microforth_pkg;

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_D   = 8'h44;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_K   = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  // Counter widths: led toggles once per 2^N clocks.
  localparam int LED_BITS_SLOW = 23;
  localparam int LED_BITS_FAST = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_W = 2'd1,
    ST_WAIT_D = 2'd2,
    ST_RESP   = 2'd3
  } parser_state_t;

endpackage

// File: rtl/microforth_uart.sv
// 8N1 UART: oversampling-free receiver sampling at mid-bit, and a
// transmitter that holds the line low/high for CLKS_PER_BIT clocks per bit.
module microforth_uart #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_start,
  output logic       o_tx_busy,
  output logic       o_txd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic          r_rxd_meta, r_rxd_sync, r_rxd_prev;
  logic          r_rx_active, r_rx_valid;
  logic [3:0]    r_rx_idx;
  logic [CW-1:0] r_rx_cnt;
  logic [7:0]    r_rx_shift;
  logic          w_rx_fall, w_rx_tick;

  logic          r_tx_active, r_txd;
  logic [3:0]    r_tx_idx;
  logic [CW-1:0] r_tx_cnt;
  logic [8:0]    r_tx_shift;

  // idx 0 is the start bit, checked half a bit in; all later bits are a full bit apart
  assign w_rx_fall = r_rxd_prev & ~r_rxd_sync;
  assign w_rx_tick = (r_rx_cnt == ((r_rx_idx == 4'd0) ? HALF_M1 : FULL_M1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rxd_meta  <= 1'b1;
      r_rxd_sync  <= 1'b1;
      r_rxd_prev  <= 1'b1;
      r_rx_active <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_idx    <= 4'd0;
      r_rx_cnt    <= {CW{1'b0}};
      r_rx_shift  <= 8'h00;
    end else begin
      r_rxd_meta <= i_rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
      r_rx_valid <= 1'b0;
      if (!r_rx_active) begin
        if (w_rx_fall) begin
          r_rx_active <= 1'b1;
          r_rx_idx    <= 4'd0;
          r_rx_cnt    <= {CW{1'b0}};
        end
      end else if (!w_rx_tick) begin
        r_rx_cnt <= r_rx_cnt + CW'(1);
      end else begin
        r_rx_cnt <= {CW{1'b0}};
        if (r_rx_idx == 4'd0) begin
          r_rx_active <= ~r_rxd_sync;
          r_rx_idx    <= 4'd1;
        end else if (r_rx_idx == 4'd9) begin
          r_rx_active <= 1'b0;
          r_rx_valid  <= r_rxd_sync;
        end else begin
          r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
          r_rx_idx   <= r_rx_idx + 4'd1;
        end
      end
    end
  end

  // Shift register carries data bits then the stop bit; start bit is driven on launch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_active <= 1'b0;
      r_txd       <= 1'b1;
      r_tx_idx    <= 4'd0;
      r_tx_cnt    <= {CW{1'b0}};
      r_tx_shift  <= 9'h1FF;
    end else if (!r_tx_active) begin
      if (i_tx_start) begin
        r_tx_active <= 1'b1;
        r_txd       <= 1'b0;
        r_tx_idx    <= 4'd0;
        r_tx_cnt    <= {CW{1'b0}};
        r_tx_shift  <= {1'b1, i_tx_byte};
      end
    end else if (r_tx_cnt != FULL_M1) begin
      r_tx_cnt <= r_tx_cnt + CW'(1);
    end else begin
      r_tx_cnt <= {CW{1'b0}};
      if (r_tx_idx == 4'd9) begin
        r_tx_active <= 1'b0;
      end else begin
        r_txd      <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        r_tx_idx   <= r_tx_idx + 4'd1;
      end
    end
  end

  assign o_rx_byte  = r_rx_shift;
  assign o_rx_valid = r_rx_valid;
  assign o_tx_busy  = r_tx_active;
  assign o_txd      = r_txd;

endmodule

// File: rtl/microforth_top.sv
// microForth bring-up top: UART command parser driving an 8-bit
// bidirectional GPIO port, plus a free-running heartbeat LED.
module microforth_top #(
  parameter int PARAM1       = 0,
  parameter int CLKS_PER_BIT = 139
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     uart_rxd,
  output logic     uart_txd,
  inout  wire [7:0] gpio,
  output logic     led
);

  import microforth_pkg::*;

  localparam int LED_BITS = (PARAM1 != 0) ? LED_BITS_FAST : LED_BITS_SLOW;

  logic [7:0]          w_rx_byte;
  logic                w_rx_valid, w_tx_busy, w_tx_start;
  parser_state_t       r_state, w_state_nxt;
  logic [7:0]          r_gpio_out, r_gpio_dir, r_resp;
  logic [7:0]          w_out_nxt, w_dir_nxt, w_resp_nxt;
  logic [7:0]          r_pad_do, r_pad_oe, r_gpio_meta, r_gpio_sync;
  logic [LED_BITS-1:0] r_led_cnt;
  logic                r_led;

  microforth_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rxd      (uart_rxd),
    .o_rx_byte  (w_rx_byte),
    .o_rx_valid (w_rx_valid),
    .i_tx_byte  (r_resp),
    .i_tx_start (w_tx_start),
    .o_tx_busy  (w_tx_busy),
    .o_txd      (uart_txd)
  );

  // Bytes arriving in ST_RESP fall through the default-hold and are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_gpio_out;
    w_dir_nxt   = r_gpio_dir;
    w_resp_nxt  = r_resp;
    w_tx_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_valid) begin
          w_state_nxt = ST_RESP;
          case (w_rx_byte)
            CMD_W:   w_state_nxt = ST_WAIT_W;
            CMD_D:   w_state_nxt = ST_WAIT_D;
            CMD_R:   w_resp_nxt  = r_gpio_sync;
            default: w_resp_nxt  = RSP_ERR;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_W: begin
        if (w_rx_valid) begin
          w_out_nxt   = w_rx_byte;
          w_resp_nxt  = RSP_K;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT_W;
        end
      end
      ST_WAIT_D: begin
        if (w_rx_valid) begin
          w_dir_nxt   = w_rx_byte;
          w_resp_nxt  = RSP_K;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT_D;
        end
      end
      ST_RESP: begin
        if (!w_tx_busy) begin
          w_tx_start  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gpio_out <= 8'h00;
      r_gpio_dir <= 8'h00;
      r_resp     <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_gpio_out <= w_out_nxt;
      r_gpio_dir <= w_dir_nxt;
      r_resp     <= w_resp_nxt;
    end
  end

  // Pad-side registers: drive/enable lag the GPIO registers by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pad_do    <= 8'h00;
      r_pad_oe    <= 8'h00;
      r_gpio_meta <= 8'h00;
      r_gpio_sync <= 8'h00;
    end else begin
      r_pad_do    <= r_gpio_out;
      r_pad_oe    <= r_gpio_dir;
      r_gpio_meta <= gpio;
      r_gpio_sync <= r_gpio_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_cnt <= {LED_BITS{1'b0}};
      r_led     <= 1'b0;
    end else begin
      r_led_cnt <= r_led_cnt + LED_BITS'(1);
      if (r_led_cnt == {LED_BITS{1'b1}}) begin
        r_led <= ~r_led;
      end
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign gpio[i] = r_pad_oe[i] ? r_pad_do[i] : 1'bz;
  end

  assign led = r_led;

endmodule

// File: tb/tb_microforth_top.sv
// Self-checking bench for microforth_top: serial command stimulus with a
// pin-level model of the GPIO port and a decoder for reply frames.
module tb_microforth_top;

  import microforth_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rxd;
  wire        uart_txd;
  wire  [7:0] gpio;
  wire        led;
  logic [7:0] tb_en, tb_val;
  logic [7:0] m_out, m_dir;
  logic [8:0] rxq[$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  microforth_top #(.PARAM1(1), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .gpio     (gpio),
    .led      (led)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reply decoder: stores {stop, data} sampled at mid-bit.
  initial begin : tx_monitor
    logic [8:0] f;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_txd === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int b = 0; b < 9; b++) begin
          repeat (CPB) @(negedge clk);
          f[b] = uart_txd;
        end
        rxq.push_back(f);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] exp);
    for (int n = 0; n < 40 * CPB && rxq.size() == 0; n++) @(negedge clk);
    if (rxq.size() == 0) check(tag, 16'hDEAD, {8'h01, exp});
    else check(tag, 16'(rxq.pop_front()), {8'h01, exp});
  endtask

  task automatic expect_none(input string tag);
    repeat (30 * CPB) @(negedge clk);
    check(tag, 16'(rxq.size()), 16'd0);
  endtask

  function automatic logic [7:0] pins_model();
    return (m_dir & m_out) | (~m_dir & tb_val);
  endfunction

  task automatic do_read(input string tag);
    logic [7:0] exp;
    exp = pins_model();
    send_byte(CMD_R, 1'b1, 4);
    expect_reply(tag, exp);
  endtask

  task automatic do_write(input string tag, input logic [7:0] v);
    send_byte(CMD_W, 1'b1, 4);
    send_byte(v, 1'b1, 4);
    expect_reply(tag, RSP_K);
    m_out = v;
  endtask

  // The bench releases pins about to become outputs before the DUT can drive them.
  task automatic do_dir(input string tag, input logic [7:0] v);
    tb_en = tb_en & ~v;
    send_byte(CMD_D, 1'b1, 4);
    send_byte(v, 1'b1, 4);
    expect_reply(tag, RSP_K);
    m_dir = v;
    tb_en = ~v;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp;
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    tb_en    = 8'hFF;
    tb_val   = 8'h5A;
    m_out    = 8'h00;
    m_dir    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", 16'(uart_txd), 16'd1);
    check("rst_led", 16'(led), 16'd0);
    check("rst_gpio_undriven", 16'(gpio), 16'h005A);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("led_toggle", 16'(led), 16'((k / 16) % 2));
    end

    do_dir("k_dir_ff", 8'hFF);
    check("gpio_out_zero", 16'(gpio), 16'(m_out));
    send_byte(CMD_W, 1'b1, 4);
    fork
      send_byte(8'hA5, 1'b1, 4);
      begin
        for (int n = 0; n < 20 * CPB && dut.w_rx_valid !== 1'b1; n++) @(negedge clk);
        check("rx_valid_seen", 16'(dut.w_rx_valid), 16'd1);
        @(posedge clk);
        @(negedge clk);
        check("gpio_plus1", 16'(gpio), 16'h0000);
        @(posedge clk);
        @(negedge clk);
        check("gpio_plus2", 16'(gpio), 16'h00A5);
      end
    join
    expect_reply("k_w_a5", RSP_K);
    m_out = 8'hA5;

    do_dir("k_dir_0f", 8'h0F);
    do_write("k_out_03", 8'h03);
    tb_val = 8'h60;
    send_byte(CMD_R, 1'b1, 4);
    expect_reply("read_63", 8'h63);

    send_byte(8'h41, 1'b1, 4);
    expect_reply("unknown_41", RSP_ERR);

    send_byte(CMD_W, 1'b0, 4);
    expect_none("framing_err");
    tb_val = 8'hB0;
    do_read("read_after_ferr");

    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    expect_none("glitch");

    send_byte(CMD_W, 1'b1, 4);
    b = 8'hA5;
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 check("rst_mid_txd", 16'(uart_txd), 16'd1);
    uart_rxd = 1'b1;
    tb_en = 8'hFF;
    m_out = 8'h00;
    m_dir = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    expect_none("rst_no_reply");
    tb_val = 8'($urandom);
    do_read("read_after_rst");
    do_dir("k_dir_ff2", 8'hFF);
    check("gpio_out_after_rst", 16'(gpio), 16'(m_out));

    do_write("k_data_is_R", CMD_R);
    do_dir("k_dir_3c", 8'h3C);
    tb_val = 8'($urandom);
    exp = pins_model();
    send_byte(CMD_R, 1'b1, 0);
    send_byte(CMD_R, 1'b1, 0);
    expect_reply("b2b_r1", exp);
    expect_reply("b2b_r2", exp);

    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0: do_write("rnd_w", 8'($urandom));
        1: do_dir("rnd_d", 8'($urandom));
        2: begin
          tb_val = 8'($urandom);
          do_read("rnd_r");
        end
        default: begin
          b = 8'($urandom);
          while (b == CMD_W || b == CMD_D || b == CMD_R) b = 8'($urandom);
          send_byte(b, 1'b1, 4);
          expect_reply("rnd_other", RSP_ERR);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microforth_top.md
Name: microforth_top

Overview:
FPGA top level of the microForth board bring-up image. Contains an 8N1 UART, a byte-command parser, and an 8-bit bidirectional GPIO port with per-pin direction control. A heartbeat LED shows that the system is running. A host controls and reads the GPIO pins over the serial link.

Parameters:
PARAM1, 0, simulation-speed flag: 0 = LED toggle period 2^23 clocks; nonzero = 2^4 clocks.
CLKS_PER_BIT, 139, clocks per UART bit (16 MHz / 115200); must be >= 8.

Ports:
clk  input  1  system clock (16 MHz nominal); single clock domain.
rst_n  input  1  asynchronous, active-low reset; asserts immediately, releases on the clock.
uart_rxd  input  1  serial receive, idle high, asynchronous to clk.
uart_txd  output  1  serial transmit, idle high.
gpio  inout  8  bidirectional pins; each pin is driven when its direction bit is 1, otherwise high-Z.
led  output  1  heartbeat.

Behaviour:
- Reset values: uart_txd=1, led=0, gpio_out=0x00, gpio_dir=0x00 (all pins high-Z), parser in IDLE, RX/TX idle, no pending response.
- Synchronisation: uart_rxd passes through a 2-flop synchroniser, reset value 1. gpio pins are read through a 2-flop synchroniser.
- RX: a falling edge in IDLE starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if the line is high, the frame is abandoned and RX returns to IDLE. The 8 data bits (LSB first) are each sampled at mid-bit, then the stop bit. Stop bit = 1: rx_valid pulses for exactly 1 cycle with the byte. Stop bit = 0 (framing error): the byte is discarded and no pulse is produced.
- TX: accepts a byte when idle. Sends start(0), 8 data bits LSB first, stop(1), each bit CLKS_PER_BIT cycles. The busy flag clears after the stop bit.
- Parser states: IDLE, WAIT_W, WAIT_D, RESP.
  - IDLE + 'W'(0x57): go to WAIT_W. The next byte is written to gpio_out, then response 'K'(0x4B).
  - IDLE + 'D'(0x44): go to WAIT_D. The next byte is written to gpio_dir, then response 'K'.
  - IDLE + 'R'(0x52): response = synchronised gpio pin value.
  - IDLE + any other byte: response '?'(0x3F).
  - WAIT_W and WAIT_D have no timeout. Any byte, including 'W', 'D' or 'R', is taken as data.
  - The register write happens in the cycle after rx_valid. The new gpio drive/direction appears on the pins on the following clock.
  - RESP: holds the single pending response until TX is idle, then launches it and returns to IDLE.
  - A byte that arrives while in RESP is dropped, with no response.
- 'R' returns the pin level as seen at the pad. Driven pins read back gpio_out; undriven pins read the external level.
- LED: a free-running counter toggles led at each wrap; period 2^23 or 2^4 clocks per PARAM1.
- Reset mid-frame: RX and TX abort. uart_txd returns to 1 asynchronously. The pending response and any partial command are lost.

Decomposition:
- Package microforth_pkg holds:
  - command byte constants 'W', 'D', 'R';
  - response constants 'K', '?';
  - the parser state enum;
  - the LED period constants.
- One sub-module, microforth_uart: contains the RX and TX engines, with a CLKS_PER_BIT parameter.
  - RX side: rx_byte, rx_valid.
  - TX side: tx_byte, tx_start, tx_busy.
- Parser, GPIO registers, tri-state buffers and LED counter sit in microforth_top.

Test Plan (CLKS_PER_BIT=16, PARAM1=1):
- Reset then release, gpio undriven by the bench -> uart_txd=1, led=0, all gpio pins Z. led toggles every 16 clocks after release.
- Send 'D',0xFF then 'W',0xA5 -> two 'K' (0x4B) frames on uart_txd. gpio=0xA5 two clocks after the second rx_valid.
- gpio_dir=0x0F, gpio_out=0x03, bench drives upper nibble to 0x6 -> send 'R' -> reply byte 0x63.
- Send 0x41 -> reply 0x3F. Send a frame with stop bit 0 -> no reply, parser stays in IDLE. A 4-clock low glitch on rxd -> no byte.
- 'W' sent, rst_n pulsed low mid-way through the data byte -> gpio_out stays 0x00, txd=1, no reply. A following 'R' answers normally.
- Back-to-back 'R','R' at full line rate -> two reply bytes, no dropped reply.
